// File: rtl/bp_pkg.sv
// +----------------------------------------------------------------------------+
// | bp_pkg                                                                     |
// | Shared types, field extraction and counter constants for branch_predictor. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package bp_pkg;

  // Fields are sized for the widest legal configuration; the top uses low bits.
  localparam int c_BP_TAG_MAX = 30;
  localparam int c_BP_CTR_MAX = 4;

  typedef struct packed {
    logic                    valid;
    logic [c_BP_TAG_MAX-1:0] tag;
    logic [30:0]             target;
    logic [c_BP_CTR_MAX-1:0] ctr;
  } bp_entry_t;

  function automatic logic [31:0] bp_idx(input logic [31:0] pc, input int idx_w);
    logic [31:0] mask;
    mask = (32'd1 << idx_w) - 32'd1;
    return (pc >> 1) & mask;
  endfunction

  function automatic logic [c_BP_TAG_MAX-1:0] bp_tag(input logic [31:0] pc,
                                                     input int idx_w, input int tag_w);
    logic [31:0] mask;
    logic [31:0] sh;
    mask = (32'd1 << tag_w) - 32'd1;
    sh   = pc >> (idx_w + 1);
    return c_BP_TAG_MAX'(sh & mask);
  endfunction

  function automatic logic [c_BP_CTR_MAX-1:0] bp_ctr_wnt(input int ctr_w);
    return c_BP_CTR_MAX'((1 << (ctr_w - 1)) - 1);
  endfunction

  function automatic logic [c_BP_CTR_MAX-1:0] bp_ctr_wt(input int ctr_w);
    return c_BP_CTR_MAX'(1 << (ctr_w - 1));
  endfunction

  function automatic logic [c_BP_CTR_MAX-1:0] bp_ctr_max(input int ctr_w);
    return c_BP_CTR_MAX'((1 << ctr_w) - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bp_sat_ctr.sv
// +----------------------------------------------------------------------------+
// | bp_sat_ctr                                                                 |
// | Saturating up/down counter next-state function, clamped at 0 and all-ones.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module bp_sat_ctr #(
  parameter int W = 2
) (
  input  logic [W-1:0] cur,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (inc && !dec && (cur != {W{1'b1}})) begin
      nxt = cur + W'(1);
    end else if (dec && !inc && (cur != '0)) begin
      nxt = cur - W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/branch_predictor.sv
// +----------------------------------------------------------------------------+
// | branch_predictor                                                           |
// | Direct-mapped tagged BTB with saturating-counter direction prediction.     |
// | Optional gshare counter table selected by macro BP_GSHARE_EN.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int TAG_W   = 8,
  parameter int GHR_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] lk_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_branch,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  input  logic        flush_all,
  output logic [31:0] cnt_hit,
  output logic [31:0] cnt_mispredict
);

  localparam int IDX_W = $clog2(ENTRIES);

  localparam logic [CTR_W-1:0] c_WNT = CTR_W'(bp_ctr_wnt(CTR_W));
  localparam logic [CTR_W-1:0] c_WT  = CTR_W'(bp_ctr_wt(CTR_W));
  localparam logic [CTR_W-1:0] c_MAX = CTR_W'(bp_ctr_max(CTR_W));

  bp_entry_t r_tbl [ENTRIES];

  logic [IDX_W-1:0]        w_lk_idx;
  logic [IDX_W-1:0]        w_upd_idx;
  logic [c_BP_TAG_MAX-1:0] w_lk_tag;
  logic [c_BP_TAG_MAX-1:0] w_upd_tag;
  bp_entry_t               w_lk_ent;
  bp_entry_t               w_upd_ent;
  logic                    w_upd_hit;
  logic [CTR_W-1:0]        w_lk_ctr;
  logic [CTR_W-1:0]        w_upd_ctr;
  logic [CTR_W-1:0]        w_upd_ctr_nxt;
  logic                    w_unused_tgt0;

  assign w_unused_tgt0 = upd_target[0];

  assign w_lk_idx  = IDX_W'(bp_idx(lk_pc, IDX_W));
  assign w_upd_idx = IDX_W'(bp_idx(upd_pc, IDX_W));
  assign w_lk_tag  = bp_tag(lk_pc, IDX_W, TAG_W);
  assign w_upd_tag = bp_tag(upd_pc, IDX_W, TAG_W);
  assign w_lk_ent  = r_tbl[w_lk_idx];
  assign w_upd_ent = r_tbl[w_upd_idx];
  assign w_upd_hit = w_upd_ent.valid && (w_upd_ent.tag == w_upd_tag);

  assign pred_hit    = w_lk_ent.valid && (w_lk_ent.tag == w_lk_tag);
  assign pred_taken  = pred_hit & w_lk_ctr[CTR_W-1];
  assign pred_target = pred_hit ? {w_lk_ent.target, 1'b0} : 32'd0;

`ifdef BP_GSHARE_EN
  // Direction counters are indexed by PC xor history; the BTB stays PC-indexed.
  logic [CTR_W-1:0] r_pht [ENTRIES];
  logic [GHR_W-1:0] r_ghr;
  logic [IDX_W-1:0] w_lk_gidx;
  logic [IDX_W-1:0] w_upd_gidx;

  assign w_lk_gidx  = w_lk_idx ^ IDX_W'(r_ghr);
  assign w_upd_gidx = w_upd_idx ^ IDX_W'(r_ghr);
  assign w_lk_ctr   = r_pht[w_lk_gidx];
  assign w_upd_ctr  = r_pht[w_upd_gidx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_pht[i] <= c_WNT;
      end
      r_ghr <= '0;
    end else if (flush_all) begin
      r_ghr <= '0;
    end else if (upd_valid) begin
      if (upd_is_branch) begin
        r_pht[w_upd_gidx] <= w_upd_ctr_nxt;
        r_ghr             <= GHR_W'({r_ghr, upd_taken});
      end else begin
        r_pht[w_upd_gidx] <= c_MAX;
      end
    end
  end
`else
  assign w_lk_ctr  = w_lk_ent.ctr[CTR_W-1:0];
  assign w_upd_ctr = w_upd_ent.ctr[CTR_W-1:0];
`endif

  bp_sat_ctr #(.W(CTR_W)) u_train_ctr (
    .cur (w_upd_ctr),
    .inc (upd_taken),
    .dec (!upd_taken),
    .nxt (w_upd_ctr_nxt)
  );

  // Flush only drops valid bits; stored counters and targets survive it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_tbl[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: c_BP_CTR_MAX'(c_WNT)};
      end
    end else if (flush_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_tbl[i].valid <= 1'b0;
      end
    end else if (upd_valid) begin
      if (!upd_is_branch) begin
        r_tbl[w_upd_idx] <= '{valid: 1'b1, tag: w_upd_tag, target: upd_target[31:1],
                              ctr: c_BP_CTR_MAX'(c_MAX)};
      end else if (w_upd_hit) begin
`ifndef BP_GSHARE_EN
        r_tbl[w_upd_idx].ctr <= c_BP_CTR_MAX'(w_upd_ctr_nxt);
`endif
        if (upd_taken) begin
          r_tbl[w_upd_idx].target <= upd_target[31:1];
        end
      end else if (upd_taken) begin
        r_tbl[w_upd_idx] <= '{valid: 1'b1, tag: w_upd_tag, target: upd_target[31:1],
                              ctr: c_BP_CTR_MAX'(c_WT)};
      end
    end
  end

  logic [31:0] r_cnt_hit;
  logic [31:0] r_cnt_mis;
  logic [31:0] w_cnt_hit_nxt;
  logic [31:0] w_cnt_mis_nxt;

  bp_sat_ctr #(.W(32)) u_cnt_hit (
    .cur (r_cnt_hit),
    .inc (pred_hit),
    .dec (1'b0),
    .nxt (w_cnt_hit_nxt)
  );

  bp_sat_ctr #(.W(32)) u_cnt_mis (
    .cur (r_cnt_mis),
    .inc (upd_valid & upd_mispredict),
    .dec (1'b0),
    .nxt (w_cnt_mis_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_hit <= '0;
      r_cnt_mis <= '0;
    end else begin
      r_cnt_hit <= w_cnt_hit_nxt;
      r_cnt_mis <= w_cnt_mis_nxt;
    end
  end

  assign cnt_hit        = r_cnt_hit;
  assign cnt_mispredict = r_cnt_mis;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// +----------------------------------------------------------------------------+
// | tb_branch_predictor                                                        |
// | Directed self-checking bench for branch_predictor (default parameters).    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_branch_predictor;

  localparam logic [31:0] c_IDLE_PC = 32'h0000_0FFE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lk_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_branch;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic        flush_all;
  logic [31:0] cnt_hit;
  logic [31:0] cnt_mispredict;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_hits = 0;
  int exp_mis  = 0;

  logic        r_h;
  logic        r_t;
  logic [31:0] r_tg;

  branch_predictor dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lk_pc          (lk_pc),
    .pred_hit       (pred_hit),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_is_branch  (upd_is_branch),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_mispredict (upd_mispredict),
    .flush_all      (flush_all),
    .cnt_hit        (cnt_hit),
    .cnt_mispredict (cnt_mispredict)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // One resolved update, committed on the next rising edge.
  task automatic do_update(input logic [31:0] pc, input logic br, input logic tk,
                           input logic [31:0] tgt, input logic mis);
    @(negedge clk);
    upd_pc = pc; upd_is_branch = br; upd_taken = tk; upd_target = tgt;
    upd_mispredict = mis; upd_valid = 1'b1;
    if (mis) exp_mis++;
    @(posedge clk);
    #1;
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  // Present a lookup PC for exactly one clock edge and capture the outputs.
  task automatic probe(input logic [31:0] pc, output logic h, output logic t,
                       output logic [31:0] tg);
    @(negedge clk);
    lk_pc = pc;
    #1;
    h = pred_hit; t = pred_taken; tg = pred_target;
    @(posedge clk);
    #1;
    lk_pc = c_IDLE_PC;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lk_pc = 32'h100; upd_valid = 1'b0; upd_pc = '0; upd_is_branch = 1'b0;
    upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0; flush_all = 1'b0;
    #3;
    n_checks++;
    if ({pred_hit, pred_taken} !== 2'b00) begin
      n_fail++; $display("FAIL reset_hit_taken: got %b want 00", {pred_hit, pred_taken});
    end
    n_checks++;
    if (pred_target !== 32'h0) begin
      n_fail++; $display("FAIL reset_target: got %h want 0", pred_target);
    end
    n_checks++;
    if (cnt_hit !== 32'h0) begin
      n_fail++; $display("FAIL reset_cnt_hit: got %0d want 0", cnt_hit);
    end
    n_checks++;
    if (cnt_mispredict !== 32'h0) begin
      n_fail++; $display("FAIL reset_cnt_mis: got %0d want 0", cnt_mispredict);
    end
    @(negedge clk);
    @(negedge clk);
    lk_pc = c_IDLE_PC;
    rst_n = 1'b1;
  endtask

  task automatic test_train_taken();
    do_update(32'h100, 1'b1, 1'b1, 32'h80, 1'b1);
    probe(32'h100, r_h, r_t, r_tg); exp_hits++;
    n_checks++;
    if ({r_h, r_t, r_tg} !== {1'b1, 1'b1, 32'h80}) begin
      n_fail++; $display("FAIL alloc_taken: got %b %b %h want 1 1 00000080", r_h, r_t, r_tg);
    end
    repeat (3) do_update(32'h100, 1'b1, 1'b1, 32'h80, 1'b0);
    probe(32'h100, r_h, r_t, r_tg); exp_hits++;
    n_checks++;
    if ({r_h, r_t, r_tg} !== {1'b1, 1'b1, 32'h80}) begin
      n_fail++; $display("FAIL saturate_taken: got %b %b %h want 1 1 00000080", r_h, r_t, r_tg);
    end
  endtask

  task automatic test_train_not_taken();
    // ctr 3 -> 2: still taken, target untouched by not-taken update
    do_update(32'h100, 1'b1, 1'b0, 32'h444, 1'b1);
    probe(32'h100, r_h, r_t, r_tg); exp_hits++;
    n_checks++;
    if ({r_h, r_t, r_tg} !== {1'b1, 1'b1, 32'h80}) begin
      n_fail++; $display("FAIL nt_ctr2: got %b %b %h want 1 1 00000080", r_h, r_t, r_tg);
    end
    do_update(32'h100, 1'b1, 1'b0, 32'h444, 1'b1);
    probe(32'h100, r_h, r_t, r_tg); exp_hits++;
    n_checks++;
    if ({r_h, r_t, r_tg} !== {1'b1, 1'b0, 32'h80}) begin
      n_fail++; $display("FAIL nt_ctr1: got %b %b %h want 1 0 00000080", r_h, r_t, r_tg);
    end
    do_update(32'h100, 1'b1, 1'b0, 32'h444, 1'b0);
    probe(32'h100, r_h, r_t, r_tg); exp_hits++;
    n_checks++;
    if ({r_h, r_t, r_tg} !== {1'b1, 1'b0, 32'h80}) begin
      n_fail++; $display("FAIL nt_ctr0: got %b %b %h want 1 0 00000080", r_h, r_t, r_tg);
    end
    // stays at 0, so one taken update only reaches 1
    do_update(32'h100, 1'b1, 1'b0, 32'h444, 1'b0);
    do_update(32'h100, 1'b1, 1'b1, 32'h80, 1'b1);
    probe(32'h100, r_h, r_t, r_tg); exp_hits++;
    n_checks++;
    if ({r_h, r_t, r_tg} !== {1'b1, 1'b0, 32'h80}) begin
      n_fail++; $display("FAIL floor_saturate: got %b %b %h want 1 0 00000080", r_h, r_t, r_tg);
    end
  endtask

  task automatic test_rvc_alias();
    do_update(32'h102, 1'b1, 1'b1, 32'h40, 1'b1);
    probe(32'h102, r_h, r_t, r_tg); exp_hits++;
    n_checks++;
    if ({r_h, r_t, r_tg} !== {1'b1, 1'b1, 32'h40}) begin
      n_fail++; $display("FAIL rvc_alloc: got %b %b %h want 1 1 00000040", r_h, r_t, r_tg);
    end
    do_update(32'h142, 1'b1, 1'b1, 32'h60, 1'b1);
    probe(32'h102, r_h, r_t, r_tg);
    n_checks++;
    if ({r_h, r_t, r_tg} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL alias_evicted: got %b %b %h want 0 0 00000000", r_h, r_t, r_tg);
    end
    probe(32'h142, r_h, r_t, r_tg); exp_hits++;
    n_checks++;
    if ({r_h, r_t, r_tg} !== {1'b1, 1'b1, 32'h60}) begin
      n_fail++; $display("FAIL alias_new: got %b %b %h want 1 1 00000060", r_h, r_t, r_tg);
    end
  endtask

  task automatic test_jal();
    do_update(32'h10C, 1'b0, 1'b1, 32'h2000, 1'b1);
    probe(32'h10C, r_h, r_t, r_tg); exp_hits++;
    n_checks++;
    if ({r_h, r_t, r_tg} !== {1'b1, 1'b1, 32'h2000}) begin
      n_fail++; $display("FAIL jal_alloc: got %b %b %h want 1 1 00002000", r_h, r_t, r_tg);
    end
    // jal allocates at MAX, so one not-taken still leaves it taken
    do_update(32'h10C, 1'b1, 1'b0, 32'h2000, 1'b1);
    probe(32'h10C, r_h, r_t, r_tg); exp_hits++;
    n_checks++;
    if ({r_h, r_t, r_tg} !== {1'b1, 1'b1, 32'h2000}) begin
      n_fail++; $display("FAIL jal_ctr_max: got %b %b %h want 1 1 00002000", r_h, r_t, r_tg);
    end
  endtask

  task automatic test_no_bypass();
    @(negedge clk);
    lk_pc = 32'h10C;
    upd_pc = 32'h10C; upd_is_branch = 1'b1; upd_taken = 1'b0; upd_target = 32'h2000;
    upd_mispredict = 1'b1; upd_valid = 1'b1; exp_mis++; exp_hits++;
    #1;
    n_checks++;
    if ({pred_hit, pred_taken} !== 2'b11) begin
      n_fail++; $display("FAIL nobypass_pre: got %b want 11", {pred_hit, pred_taken});
    end
    @(posedge clk);
    #1;
    upd_valid = 1'b0; upd_mispredict = 1'b0; lk_pc = c_IDLE_PC;
    probe(32'h10C, r_h, r_t, r_tg); exp_hits++;
    n_checks++;
    if ({r_h, r_t, r_tg} !== {1'b1, 1'b0, 32'h2000}) begin
      n_fail++; $display("FAIL nobypass_post: got %b %b %h want 1 0 00002000", r_h, r_t, r_tg);
    end
    @(negedge clk);
    lk_pc = 32'h1E4;
    upd_pc = 32'h1E4; upd_is_branch = 1'b1; upd_taken = 1'b1; upd_target = 32'h300;
    upd_mispredict = 1'b1; upd_valid = 1'b1; exp_mis++;
    #1;
    n_checks++;
    if (pred_hit !== 1'b0) begin
      n_fail++; $display("FAIL nobypass_alloc_pre: got %b want 0", pred_hit);
    end
    @(posedge clk);
    #1;
    upd_valid = 1'b0; upd_mispredict = 1'b0; lk_pc = c_IDLE_PC;
    probe(32'h1E4, r_h, r_t, r_tg); exp_hits++;
    n_checks++;
    if ({r_h, r_t, r_tg} !== {1'b1, 1'b1, 32'h300}) begin
      n_fail++; $display("FAIL nobypass_alloc_post: got %b %b %h want 1 1 00000300", r_h, r_t, r_tg);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    flush_all = 1'b1;
    upd_pc = 32'h200; upd_is_branch = 1'b1; upd_taken = 1'b1; upd_target = 32'h900;
    upd_mispredict = 1'b1; upd_valid = 1'b1; exp_mis++;
    @(posedge clk);
    #1;
    flush_all = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
    probe(32'h100, r_h, r_t, r_tg);
    n_checks++;
    if ({r_h, r_t, r_tg} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL flush_old_entry: got %b %b %h want 0 0 00000000", r_h, r_t, r_tg);
    end
    probe(32'h200, r_h, r_t, r_tg);
    n_checks++;
    if ({r_h, r_t, r_tg} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL flush_drops_update: got %b %b %h want 0 0 00000000", r_h, r_t, r_tg);
    end
    probe(32'h1E4, r_h, r_t, r_tg);
    n_checks++;
    if (r_h !== 1'b0) begin
      n_fail++; $display("FAIL flush_other_entry: got %b want 0", r_h);
    end
    n_checks++;
    if (cnt_mispredict !== 32'(exp_mis)) begin
      n_fail++; $display("FAIL flush_cnt_mis: got %0d want %0d", cnt_mispredict, exp_mis);
    end
  endtask

  task automatic test_alternating();
    int   n_mp;
    int   n_iter;
    int   n_warm;
    logic outcome;
    logic exp_t;
    logic obs_h;
    logic obs_t;
    n_mp = 0;
`ifdef BP_GSHARE_EN
    n_iter = 24; n_warm = 8;
`else
    n_iter = 16; n_warm = 0;
`endif
    for (int i = 0; i < n_iter; i++) begin
      outcome = (i % 2 == 0);
      exp_t   = (i % 2 == 1);
      @(negedge clk);
      lk_pc = 32'h300;
      #1;
      obs_h = pred_hit; obs_t = pred_taken;
      upd_pc = 32'h300; upd_is_branch = 1'b1; upd_taken = outcome; upd_target = 32'h380;
      upd_mispredict = (obs_t != outcome); upd_valid = 1'b1;
      if (i > 0) exp_hits++;
      if (i >= n_warm && obs_t != outcome) n_mp++;
`ifdef BP_GSHARE_EN
      if (obs_t != outcome) exp_mis++;
`else
      if (exp_t != outcome) exp_mis++;
      n_checks++;
      if ({obs_h, obs_t} !== {(i > 0), exp_t}) begin
        n_fail++; $display("FAIL alt_iter%0d: got %b%b want %b%b", i, obs_h, obs_t, (i > 0), exp_t);
      end
`endif
      @(posedge clk);
      #1;
      upd_valid = 1'b0; upd_mispredict = 1'b0; lk_pc = c_IDLE_PC;
    end
`ifdef BP_GSHARE_EN
    n_checks++;
    if (n_mp != 0) begin
      n_fail++; $display("FAIL gshare_alternating: got %0d mispredicts want 0", n_mp);
    end
`else
    n_checks++;
    if (n_mp < 8) begin
      n_fail++; $display("FAIL bimodal_alternating: got %0d mispredicts want >= 8", n_mp);
    end
`endif
  endtask

  task automatic test_perf_counters();
    @(negedge clk);
    n_checks++;
    if (cnt_hit !== 32'(exp_hits)) begin
      n_fail++; $display("FAIL cnt_hit: got %0d want %0d", cnt_hit, exp_hits);
    end
    n_checks++;
    if (cnt_mispredict !== 32'(exp_mis)) begin
      n_fail++; $display("FAIL cnt_mispredict: got %0d want %0d", cnt_mispredict, exp_mis);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    lk_pc = 32'h300;
    upd_pc = 32'h300; upd_is_branch = 1'b1; upd_taken = 1'b1; upd_target = 32'h380;
    upd_mispredict = 1'b1; upd_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pred_hit, pred_taken, pred_target} !== {1'b0, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL async_reset_outputs: got %b %b %h want 0 0 00000000", pred_hit, pred_taken, pred_target);
    end
    n_checks++;
    if ({cnt_hit, cnt_mispredict} !== 64'h0) begin
      n_fail++; $display("FAIL async_reset_counters: got %0d %0d want 0 0", cnt_hit, cnt_mispredict);
    end
    @(posedge clk);
    #1;
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    @(negedge clk);
    lk_pc = c_IDLE_PC;
    rst_n = 1'b1;
    probe(32'h300, r_h, r_t, r_tg);
    n_checks++;
    if ({r_h, r_t, r_tg, cnt_mispredict} !== {1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_fail++; $display("FAIL async_reset_table: got %b %b %h %0d want 0 0 00000000 0", r_h, r_t, r_tg, cnt_mispredict);
    end
  endtask

  initial begin
    test_reset();
    test_train_taken();
    test_train_not_taken();
    test_rvc_alias();
    test_jal();
    test_no_bypass();
    test_flush();
    test_alternating();
    test_perf_counters();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
